input_port_controller: RTL and testbench
========================================

// Module: input_port_controller
// PURPOSE
//  Router input-port stage that sits directly upstream of the head-flit decoder.
//  - Buffers incoming flits in a FIFO.
//  - Presents the head flit to the decoder and latches the returned RequestMessage.
//  - Requests that output port from the switch allocator.
//  - Once granted, streams head, body and tail flits to the crossbar, then releases the port.
// PARAMETERS
//  DATA_WIDTH     8   phit width in bits
//  PhitPerFlit    2   phits per flit; FLIT_W = PhitPerFlit*DATA_WIDTH
//  REQUEST_WIDTH  3   width of the encoded output-port request (decoder output)
//  BUFFER_DEPTH   4   FIFO depth in flits (power of 2, >=2)
// PORTS
//  clk              in   1              rising-edge clock
//  rst              in   1              asynchronous, active-high reset
//  in_data          in   FLIT_W         incoming flit; type field = in_data[FLIT_W-1 -: 2]
//  in_valid         in   1              upstream flit valid
//  in_ready         out  1              FIFO can accept a flit
//  decodeHeadFlit   out  1              decode request to the head-flit decoder
//  HeadFlit         out  FLIT_W         FIFO head flit, driven to the decoder
//  headFlitDecoded  in   1              decoder done (may arrive in the same cycle)
//  RequestMessage   in   REQUEST_WIDTH  decoded output port
//  portRequest      out  1              request valid to the switch allocator
//  requestedPort    out  REQUEST_WIDTH  latched port being requested or held
//  portGrant        in   1              allocator grant (level)
//  portRelease      out  1              1-cycle pulse when the tail leaves
//  out_data         out  FLIT_W         flit to the crossbar
//  out_valid        out  1              out_data valid
//  out_ready        in   1              crossbar accepts the flit
//  dropPulse        out  1              1-cycle pulse: stray non-head flit discarded
// BEHAVIOUR
//  Flit types (top 2 bits): 01 HEAD, 10 BODY, 11 TAIL, 00 HEAD_TAIL (single-flit packet).
//  Reset: FIFO empty, state IDLE, requestedPort=0.
//    All outputs 0 except in_ready=1. HeadFlit/out_data then show the (stale) FIFO head entry.
//  FIFO:
//    - Push when in_valid&&in_ready.
//    - in_ready = !full; a pop in the same cycle does NOT enable a push when full (no bypass).
//    - Pointers wrap modulo BUFFER_DEPTH; count is $clog2(BUFFER_DEPTH)+1 bits.
//    - A flit pushed in cycle t is visible at the FIFO head in cycle t+1.
//    - Simultaneous push and pop leaves count unchanged.
//  HeadFlit and out_data are both driven combinationally from the FIFO head entry.
//  FSM:
//   IDLE:
//    - If FIFO nonempty and head type is HEAD or HEAD_TAIL -> DECODE next cycle.
//    - If head type is BODY/TAIL: pop it, pulse dropPulse, stay IDLE.
//   DECODE:
//    - decodeHeadFlit=1.
//    - When headFlitDecoded=1: latch RequestMessage into requestedPort -> REQUEST.
//    - The head flit is not popped.
//   REQUEST:
//    - portRequest=1 with requestedPort stable.
//    - When portGrant=1 -> TRANSFER next cycle.
//   TRANSFER:
//    - out_valid = !empty; pop on out_valid&&out_ready.
//    - Popping a TAIL or HEAD_TAIL flit: portRelease=1 in that same cycle, -> IDLE.
//    - portGrant is ignored in TRANSFER; the port is held until the tail.
//    - Empty FIFO mid-packet: out_valid=0, remain in TRANSFER.
//  Minimum latency, head at FIFO head in cycle h, with combinational decode and immediate grant:
//    IDLE(h) -> DECODE(h+1) -> REQUEST(h+2) -> first out_valid at h+3.
//  Only one packet is in flight; the next head waits in the FIFO behind the current tail.
//  rst asserted mid-packet: immediate return to the reset state; buffered flits are discarded.
// TESTING
//  1. Reset with a packet mid-TRANSFER -> in_ready=1, out_valid=0, portRequest=0 immediately.
//  2. HEAD(dest 0x12)+BODY+TAIL, decoder returns RequestMessage=2 same cycle,
//     grant on 1st request cycle -> requestedPort=2;
//     3 flits out in order starting 3 cycles after head is visible;
//     portRelease pulses with the TAIL pop.
//  3. Push 4 flits with out_ready=0 (DEPTH=4) -> in_ready=0 after the 4th;
//     a 5th in_valid is not accepted until the first pop.
//  4. BODY flit arrives while IDLE -> dropPulse 1 cycle, FIFO empty, no decode.
//  5. HEAD_TAIL flit, grant delayed 5 cycles ->
//     portRequest held for 5 cycles with stable requestedPort; one flit out;
//     portRelease in the same cycle as its pop.
//  6. Two back-to-back 2-flit packets, out_ready toggling 1010 ->
//     second DECODE only after the first TAIL pop; all flits in order, no loss or duplication.

Source files
------------

// File: rtl/input_port_controller.sv
// Router input port: flit FIFO, head decode handshake, switch
// allocation request and packet streaming to the crossbar.
module input_port_controller #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int PhitPerFlit   = 2,
    parameter  int REQUEST_WIDTH = 3,
    parameter  int BUFFER_DEPTH  = 4,
    localparam int FLIT_W        = PhitPerFlit * DATA_WIDTH,
    localparam int PtrW          = $clog2(BUFFER_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     decodeHeadFlit,
    output logic [FLIT_W-1:0]        HeadFlit,
    input  logic                     headFlitDecoded,
    input  logic [REQUEST_WIDTH-1:0] RequestMessage,
    output logic                     portRequest,
    output logic [REQUEST_WIDTH-1:0] requestedPort,
    input  logic                     portGrant,
    output logic                     portRelease,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     dropPulse
);

    typedef enum logic [1:0] {
        Idle,
        Decode,
        Request,
        Transfer
    } state_t;

    localparam logic [1:0] TypeHead     = 2'b01;
    localparam logic [1:0] TypeHeadTail = 2'b00;
    localparam logic [1:0] TypeTail     = 2'b11;

    state_t state;
    state_t nextState;

    logic [FLIT_W-1:0] mem [BUFFER_DEPTH];
    logic [PtrW-1:0]   wrPtr;
    logic [PtrW-1:0]   rdPtr;
    logic [PtrW:0]     count;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [FLIT_W-1:0] headEntry;
    logic [1:0]        headType;
    logic              isHead;
    logic              isTail;

    assign empty     = (count == '0);
    assign full      = (count == (PtrW+1)'(BUFFER_DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign headEntry = mem[rdPtr];
    assign HeadFlit  = headEntry;
    assign out_data  = headEntry;
    assign headType  = headEntry[FLIT_W-1 -: 2];
    assign isHead    = (headType == TypeHead) || (headType == TypeHeadTail);
    assign isTail    = (headType == TypeTail) || (headType == TypeHeadTail);

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PtrW'(1);
            if (pop)  rdPtr <= rdPtr + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= Idle;
            requestedPort <= '0;
        end else begin
            state <= nextState;
            if (state == Decode && headFlitDecoded)
                requestedPort <= RequestMessage;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            Idle:     if (!empty && isHead) nextState = Decode;
            Decode:   if (headFlitDecoded) nextState = Request;
            Request:  if (portGrant) nextState = Transfer;
            Transfer: if (!empty && out_ready && isTail) nextState = Idle;
            default:  nextState = Idle;
        endcase
    end

    always_comb begin
        decodeHeadFlit = 1'b0;
        portRequest    = 1'b0;
        out_valid      = 1'b0;
        portRelease    = 1'b0;
        dropPulse      = 1'b0;
        pop            = 1'b0;
        unique case (state)
            Idle: begin
                // A body/tail with no preceding head has no route.
                if (!empty && !isHead) begin
                    dropPulse = 1'b1;
                    pop       = 1'b1;
                end
            end
            Decode:  decodeHeadFlit = 1'b1;
            Request: portRequest    = 1'b1;
            Transfer: begin
                out_valid   = !empty;
                pop         = !empty && out_ready;
                portRelease = !empty && out_ready && isTail;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_input_port_controller.sv
// Directed cycle-by-cycle vectors for input_port_controller,
// plus a hand-written empty-mid-packet sequence.
module tb_input_port_controller;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        decodeHeadFlit;
    logic [15:0] HeadFlit;
    logic        headFlitDecoded;
    logic [2:0]  RequestMessage;
    logic        portRequest;
    logic [2:0]  requestedPort;
    logic        portGrant;
    logic        portRelease;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        dropPulse;

    input_port_controller #(
        .DATA_WIDTH(8),
        .PhitPerFlit(2),
        .REQUEST_WIDTH(3),
        .BUFFER_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .decodeHeadFlit(decodeHeadFlit),
        .HeadFlit(HeadFlit),
        .headFlitDecoded(headFlitDecoded),
        .RequestMessage(RequestMessage),
        .portRequest(portRequest),
        .requestedPort(requestedPort),
        .portGrant(portGrant),
        .portRelease(portRelease),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dropPulse(dropPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] d;
        logic        dcd;
        logic [2:0]  rm;
        logic        g;
        logic        ordy;
        logic        eRdy;
        logic        eDec;
        logic        eReq;
        logic [2:0]  ePort;
        logic        eRel;
        logic        eOv;
        logic [15:0] eOd;
        logic        eDrop;
    } vec_t;

    vec_t vecs[$];
    int   nVec;
    int   nMis;

    task automatic add(input int r, input int v, input int d,
                       input int dc, input int rm, input int g,
                       input int o, input int eR, input int eD,
                       input int eQ, input int eP, input int eL,
                       input int eV, input int eO, input int eX);
        vec_t t;
        t.rst   = 1'(r);
        t.vld   = 1'(v);
        t.d     = 16'(d);
        t.dcd   = 1'(dc);
        t.rm    = 3'(rm);
        t.g     = 1'(g);
        t.ordy  = 1'(o);
        t.eRdy  = 1'(eR);
        t.eDec  = 1'(eD);
        t.eReq  = 1'(eQ);
        t.ePort = 3'(eP);
        t.eRel  = 1'(eL);
        t.eOv   = 1'(eV);
        t.eOd   = 16'(eO);
        t.eDrop = 1'(eX);
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s #%0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {in_ready, decodeHeadFlit, portRequest, requestedPort,
                portRelease, out_valid, dropPulse};
    endfunction

    initial begin
        nVec = 0;
        nMis = 0;
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        headFlitDecoded = 1'b0;
        RequestMessage = '0;
        portGrant = 1'b0;
        out_ready = 1'b0;

        // reset state, then reset asserted mid-transfer
        add(0,1,'h4012,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,1,'h80AA,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,0,0,1,7,0,0,      1,1,0,0,0,0,0,0);
        add(0,0,0,0,0,1,0,      1,0,1,7,0,0,0,0);
        add(0,0,0,0,0,0,0,      1,0,0,7,0,1,'h4012,0);
        add(1,0,0,0,0,0,0,      1,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,      1,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,0,0,0,0,0);
        // HEAD+BODY+TAIL, same-cycle decode, immediate grant
        add(0,1,'h4012,0,0,0,1, 1,0,0,0,0,0,0,0);
        add(0,1,'h80AA,0,0,0,1, 1,0,0,0,0,0,0,0);
        add(0,1,'hC0BB,1,2,0,1, 1,1,0,0,0,0,0,0);
        add(0,0,0,0,0,1,1,      1,0,1,2,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,1,'h4012,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,1,'h80AA,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,1,1,'hC0BB,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,0,0,0);
        // stray BODY in IDLE
        add(0,1,'h80CC,0,0,0,1, 1,0,0,2,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,0,0,1);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,0,0,0);
        // HEAD_TAIL, grant after 5 request cycles
        add(0,1,'h0033,0,0,0,1, 1,0,0,2,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,2,0,0,0,0);
        add(0,0,0,1,5,0,1,      1,1,0,2,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,0,0,1,  1,0,1,5,0,0,0,0);
        add(0,0,0,0,0,1,1,      1,0,1,5,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,5,1,1,'h0033,0);
        add(0,0,0,0,0,0,1,      1,0,0,5,0,0,0,0);
        // fill to full, 5th flit held off until a pop frees a slot
        add(0,1,'h4011,0,0,0,0, 1,0,0,5,0,0,0,0);
        add(0,1,'h8021,0,0,0,0, 1,0,0,5,0,0,0,0);
        add(0,1,'h8022,0,0,0,0, 1,1,0,5,0,0,0,0);
        add(0,1,'hC023,0,0,0,0, 1,1,0,5,0,0,0,0);
        add(0,1,'h0044,1,1,0,0, 0,1,0,5,0,0,0,0);
        add(0,1,'h0044,0,0,1,0, 0,0,1,1,0,0,0,0);
        add(0,1,'h0044,0,0,0,0, 0,0,0,1,0,1,'h4011,0);
        add(0,1,'h0044,0,0,0,1, 0,0,0,1,0,1,'h4011,0);
        add(0,1,'h0044,0,0,0,1, 1,0,0,1,0,1,'h8021,0);
        add(0,0,0,0,0,0,1,      1,0,0,1,0,1,'h8022,0);
        add(0,0,0,0,0,0,1,      1,0,0,1,1,1,'hC023,0);
        add(0,0,0,0,0,0,1,      1,0,0,1,0,0,0,0);
        add(0,0,0,1,3,0,1,      1,1,0,1,0,0,0,0);
        add(0,0,0,0,0,1,1,      1,0,1,3,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,3,1,1,'h0044,0);
        add(0,0,0,0,0,0,1,      1,0,0,3,0,0,0,0);
        // two back-to-back 2-flit packets, out_ready toggling
        add(0,1,'h4101,0,0,0,1, 1,0,0,3,0,0,0,0);
        add(0,1,'hC102,0,0,0,1, 1,0,0,3,0,0,0,0);
        add(0,1,'h4203,1,4,0,1, 1,1,0,3,0,0,0,0);
        add(0,1,'hC204,0,0,1,1, 1,0,1,4,0,0,0,0);
        add(0,0,0,0,0,0,1,      0,0,0,4,0,1,'h4101,0);
        add(0,0,0,0,0,0,0,      1,0,0,4,0,1,'hC102,0);
        add(0,0,0,0,0,0,1,      1,0,0,4,1,1,'hC102,0);
        add(0,0,0,0,0,0,0,      1,0,0,4,0,0,0,0);
        add(0,0,0,1,6,0,1,      1,1,0,4,0,0,0,0);
        add(0,0,0,0,0,1,0,      1,0,1,6,0,0,0,0);
        add(0,0,0,0,0,0,1,      1,0,0,6,0,1,'h4203,0);
        add(0,0,0,0,0,0,0,      1,0,0,6,0,1,'hC204,0);
        add(0,0,0,0,0,0,1,      1,0,0,6,1,1,'hC204,0);
        add(0,0,0,0,0,0,1,      1,0,0,6,0,0,0,0);

        @(negedge clk);
        @(negedge clk);
        foreach (vecs[i]) begin
            rst             = vecs[i].rst;
            in_valid        = vecs[i].vld;
            in_data         = vecs[i].d;
            headFlitDecoded = vecs[i].dcd;
            RequestMessage  = vecs[i].rm;
            portGrant       = vecs[i].g;
            out_ready       = vecs[i].ordy;
            #1;
            chk("outs", i, 32'(outs()),
                32'({vecs[i].eRdy, vecs[i].eDec, vecs[i].eReq,
                     vecs[i].ePort, vecs[i].eRel, vecs[i].eOv,
                     vecs[i].eDrop}));
            if (vecs[i].eOv)
                chk("out_data", i, 32'(out_data), 32'(vecs[i].eOd));
            @(negedge clk);
        end

        // FIFO runs dry mid-packet: hold TRANSFER with out_valid low
        in_data = 16'h4055;
        in_valid = 1'b1;
        headFlitDecoded = 1'b1;
        RequestMessage = 3'd2;
        portGrant = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid) break;
            @(negedge clk);
        end
        chk("dry_first_valid", 100, 32'(out_valid), 32'd1);
        chk("dry_first_data", 101, 32'(out_data), 32'h4055);
        @(negedge clk);
        #1;
        chk("dry_gap1", 102, 32'({out_valid, portRelease}), 32'd0);
        @(negedge clk);
        #1;
        chk("dry_gap2", 103, 32'({out_valid, portRelease}), 32'd0);
        in_data = 16'hC056;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("dry_tail", 104, 32'({out_valid, portRelease, out_data}),
            32'({1'b1, 1'b1, 16'hC056}));
        @(negedge clk);
        #1;
        chk("dry_after", 105,
            32'({out_valid, decodeHeadFlit, requestedPort}),
            32'({1'b0, 1'b0, 3'd2}));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
